axi4_slave_mem: RTL and testbench
=================================

AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low (ports ACLK, ARESETn).
REQ-002 Parameter DATA_W, default 32, SHALL set the data bus width in bits (32 or 64); BYTES = DATA_W/8.
REQ-003 Parameter ADDR_W, default 32, SHALL set the AWADDR/ARADDR width.
REQ-004 Parameter ID_W, default 4, SHALL set the AWID/BID/ARID/RID width.
REQ-005 Parameter DEPTH, default 256, SHALL set the memory size in DATA_W words.
REQ-006 ACLK  in  1  clock; all logic on the rising edge.
REQ-007 ARESETn  in  1  asynchronous active-low reset.
REQ-008 AWVALID  in  1  write address valid.
REQ-009 AWREADY  out  1  write address accepted.
REQ-010 AWID  in  ID_W  write transaction ID.
REQ-011 AWADDR  in  ADDR_W  start byte address.
REQ-012 AWLEN  in  8  beats minus one.
REQ-013 AWBURST  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
REQ-014 WVALID  in  1  write data valid.
REQ-015 WREADY  out  1  write data accepted.
REQ-016 WDATA  in  DATA_W  write beat data.
REQ-017 WSTRB  in  BYTES  byte enables.
REQ-018 WLAST  in  1  final write beat.
REQ-019 BVALID  out  1  write response valid.
REQ-020 BREADY  in  1  master accepts response.
REQ-021 BID  out  ID_W  latched AWID.
REQ-022 BRESP  out  2  0 OKAY, 2 SLVERR.
REQ-023 ARVALID  in  1  read address valid.
REQ-024 ARREADY  out  1  read address accepted.
REQ-025 ARID  in  ID_W  read transaction ID.
REQ-026 ARADDR  in  ADDR_W  start byte address.
REQ-027 ARLEN  in  8  beats minus one.
REQ-028 ARBURST  in  2  burst type, encoded as AWBURST.
REQ-029 RVALID  out  1  read data valid.
REQ-030 RREADY  in  1  master accepts read beat.
REQ-031 RID  out  ID_W  latched ARID.
REQ-032 RDATA  out  DATA_W  read beat data.
REQ-033 RRESP  out  2  0 OKAY, 2 SLVERR.
REQ-034 RLAST  out  1  final read beat.

Function
REQ-035 Every transfer SHALL be full width; the start address SHALL be aligned down to BYTES; word index = addr/BYTES.
REQ-036 Address advance per beat SHALL be: FIXED constant; INCR +BYTES; WRAP +BYTES, wrapping within a BYTES*(LEN+1)-aligned window; reserved type SHALL advance as INCR and force SLVERR.
REQ-037 WRAP with LEN not in {1,3,7,15} SHALL advance as INCR and force SLVERR.
REQ-038 Write FSM W_IDLE (AWREADY=1) -> W_DATA on AWVALID&AWREADY, latching ID/addr/len/burst; W_DATA (WREADY=1) writes WDATA bytes where WSTRB=1 on each WVALID&WREADY; -> W_RESP on the WLAST beat; W_RESP (BVALID=1) -> W_IDLE on BREADY.
REQ-039 WLAST on a beat other than beat LEN, or absent on beat LEN, SHALL set SLVERR; the burst SHALL end only at WLAST.
REQ-040 A beat whose word index >= DEPTH SHALL be dropped (write) or return 0 (read) and SHALL set SLVERR for that beat (read) or the burst (write).
REQ-041 Read FSM R_IDLE (ARREADY=1) -> R_DATA on ARVALID&ARREADY; first RVALID SHALL assert the next cycle; beats SHALL issue back-to-back while RREADY=1; RLAST=1 on beat ARLEN; -> R_IDLE after the RLAST handshake.
REQ-042 While VALID=1 and READY=0, all payload outputs of that channel SHALL hold stable.
REQ-043 Read and write channels SHALL operate concurrently; a same-cycle read and write to one word SHALL read the old value.
REQ-044 At most one write and one read burst SHALL be outstanding; AWREADY/ARREADY SHALL be 0 outside the idle states.

Reset
REQ-045 On ARESETn=0 every output SHALL be 0, both FSMs SHALL enter idle, and any burst in progress SHALL be aborted without response; memory contents SHALL not be reset; AWREADY/ARREADY SHALL be 1 in the first cycle after release.

Verification
REQ-046 INCR write AWADDR=0x10, AWLEN=3, data 1..4, WSTRB=F -> BRESP=0, BID=AWID; INCR read of same -> 1,2,3,4, RLAST on beat 4 only.
REQ-047 WRAP read ARADDR=0x18, ARLEN=3, DATA_W=32 -> word addresses 0x18,0x1C,0x10,0x14.
REQ-048 Write WSTRB=0x3, WDATA=0xAABBCCDD over 0x11223344 -> read returns 0x1122CCDD.
REQ-049 Read at word index DEPTH-1 with ARLEN=1 -> beat 1 OKAY with data, beat 2 RDATA=0, RRESP=2.
REQ-050 RREADY held 0 for 3 cycles mid-burst -> RDATA/RID/RLAST stable; ARESETn pulsed low mid-write -> BVALID stays 0, AWREADY=1 after release.

Source files
------------

// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a word-wide memory array: one write burst and one read
// burst in flight at a time, with FIXED/INCR/WRAP addressing and SLVERR on misuse.
module axi4_slave_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 256
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [7:0]          AWLEN,
    input  logic [1:0]          AWBURST,
    input  logic                WVALID,
    output logic                WREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    output logic                BVALID,
    input  logic                BREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    input  logic                ARVALID,
    output logic                ARREADY,
    input  logic [ID_W-1:0]     ARID,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [7:0]          ARLEN,
    input  logic [1:0]          ARBURST,
    output logic                RVALID,
    input  logic                RREADY,
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST
);
    localparam int BYTES = DATA_W / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic wrap_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic burst_err(input logic [7:0] len, input logic [1:0] burst);
        return (burst == 2'd3) || ((burst == 2'd2) && !wrap_ok(len));
    endfunction

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(BYTES - 1);
    endfunction

    // Illegal WRAP lengths and the reserved encoding fall through to INCR.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [7:0] len,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] mask;
        inc  = a + ADDR_W'(BYTES);
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << LB) - ADDR_W'(1);
        next_addr = inc;
        if (burst == 2'd0)
            next_addr = a;
        else if ((burst == 2'd2) && wrap_ok(len))
            next_addr = (a & ~mask) | (inc & mask);
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> LB) < ADDR_W'(DEPTH);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return a[LB +: IW];
    endfunction

    // ---------------- write channel ----------------
    w_state_t          w_state, w_next;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len, w_beat;
    logic [1:0]        w_burst;
    logic              w_err, aw_hs, w_hs, beat_err;

    assign AWREADY  = (w_state == W_IDLE) && ARESETn;
    assign WREADY   = (w_state == W_DATA);
    assign BVALID   = (w_state == W_RESP);
    assign aw_hs    = AWVALID && AWREADY;
    assign w_hs     = WVALID && WREADY;
    assign beat_err = !in_range(w_addr) || (WLAST != (w_beat == w_len));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && WLAST) w_next = W_RESP;
            W_RESP:  if (BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
            BID     <= '0;
            BRESP   <= '0;
        end else begin
            if (aw_hs) begin
                w_addr  <= align(AWADDR);
                w_len   <= AWLEN;
                w_burst <= AWBURST;
                w_beat  <= '0;
                w_err   <= burst_err(AWLEN, AWBURST);
                BID     <= AWID;
            end
            if (w_hs) begin
                w_addr <= next_addr(w_addr, w_len, w_burst);
                w_beat <= w_beat + 8'd1;
                w_err  <= w_err || beat_err;
                if (WLAST) BRESP <= (w_err || beat_err) ? 2'b10 : 2'b00;
            end
        end
    end

    // Memory contents survive reset; out-of-range beats are simply dropped.
    always_ff @(posedge ACLK) begin
        if (w_hs && in_range(w_addr)) begin
            for (int b = 0; b < BYTES; b++) begin
                if (WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t          r_state, r_next;
    logic [ADDR_W-1:0] r_addr, fetch_addr;
    logic [7:0]        r_len, r_beat;
    logic [1:0]        r_burst;
    logic              r_err, ar_hs, r_hs, ar_err;
    logic [DATA_W-1:0] rd_word;

    assign ARREADY    = (r_state == R_IDLE) && ARESETn;
    assign RVALID     = (r_state == R_DATA);
    assign ar_hs      = ARVALID && ARREADY;
    assign r_hs       = RVALID && RREADY;
    assign ar_err     = burst_err(ARLEN, ARBURST);
    assign fetch_addr = ar_hs ? align(ARADDR) : next_addr(r_addr, r_len, r_burst);
    assign rd_word    = in_range(fetch_addr) ? mem[word_idx(fetch_addr)] : '0;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && RLAST) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Payload registers load only on AR acceptance or a completed beat, so they
    // hold still while the master stalls.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
            RID     <= '0;
            RDATA   <= '0;
            RRESP   <= '0;
            RLAST   <= 1'b0;
        end else if (ar_hs) begin
            r_addr  <= fetch_addr;
            r_len   <= ARLEN;
            r_burst <= ARBURST;
            r_beat  <= '0;
            r_err   <= ar_err;
            RID     <= ARID;
            RDATA   <= rd_word;
            RRESP   <= (ar_err || !in_range(fetch_addr)) ? 2'b10 : 2'b00;
            RLAST   <= (ARLEN == 8'd0);
        end else if (r_hs && !RLAST) begin
            r_addr <= fetch_addr;
            r_beat <= r_beat + 8'd1;
            RDATA  <= rd_word;
            RRESP  <= (r_err || !in_range(fetch_addr)) ? 2'b10 : 2'b00;
            RLAST  <= ((r_beat + 8'd1) == r_len);
        end
    end
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Bench for axi4_slave_mem: directed and random bursts, expected responses
// queued from a byte-level memory model and checked by an independent monitor.
module tb_axi4_slave_mem;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int DEPTH  = 256;
    localparam int BYTES  = 4;

    logic              ACLK, ARESETn;
    logic              AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic [ID_W-1:0]   AWID, BID, ARID, RID;
    logic [ADDR_W-1:0] AWADDR, ARADDR;
    logic [7:0]        AWLEN, ARLEN;
    logic [1:0]        AWBURST, ARBURST, BRESP, RRESP;
    logic [DATA_W-1:0] WDATA, RDATA;
    logic [BYTES-1:0]  WSTRB;
    logic              ARVALID, ARREADY, RVALID, RREADY, RLAST;

    axi4_slave_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
        .AWLEN(AWLEN), .AWBURST(AWBURST),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARADDR(ARADDR),
        .ARLEN(ARLEN), .ARBURST(ARBURST),
        .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA),
        .RRESP(RRESP), .RLAST(RLAST)
    );

    // ---------------- clock / reset ----------------
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int tests = 0;
    int fails = 0;

    logic [31:0] model_mem [DEPTH];
    logic [5:0]  exp_b_q[$];          // {BID, BRESP}
    logic [38:0] exp_r_q[$];          // {RID, RRESP, RLAST, RDATA}
    logic [31:0] wd [64];
    logic [3:0]  ws [64];
    bit          r_auto = 1'b1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Response-side ready generators: random back-pressure.
    initial begin
        BREADY = 1'b0;
        RREADY = 1'b0;
        forever begin
            @(posedge ACLK);
            #1;
            BREADY = ($urandom_range(0, 3) != 0);
            if (r_auto) RREADY = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge ACLK);
            if (BVALID && BREADY) begin
                if (exp_b_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL b_unexpected: got BID=%0h BRESP=%0h, expected no response", BID, BRESP);
                end else check("b_resp", {BID, BRESP}, exp_b_q.pop_front());
            end
            if (RVALID && RREADY) begin
                if (exp_r_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL r_unexpected: got RID=%0h RDATA=%0h, expected no beat", RID, RDATA);
                end else check("r_beat", {RID, RRESP, RLAST, RDATA}, exp_r_q.pop_front());
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic bit wrap_len_ok(input int len);
        return (len == 1) || (len == 3) || (len == 7) || (len == 15);
    endfunction

    function automatic bit burst_bad(input int len, input int burst);
        return (burst == 3) || (burst == 2 && !wrap_len_ok(len));
    endfunction

    function automatic int beat_addr(input int start, input int len, input int burst, input int i);
        int s, wsize, base;
        s = start - (start % BYTES);
        if (burst == 0) return s;
        if (burst == 2 && wrap_len_ok(len)) begin
            wsize = BYTES * (len + 1);
            base  = s - (s % wsize);
            return base + ((s - base + i * BYTES) % wsize);
        end
        return s + i * BYTES;
    endfunction

    // ---------------- drivers ----------------
    function automatic logic rdy(input int which);
        case (which)
            0:       return AWREADY;
            1:       return WREADY;
            default: return ARREADY;
        endcase
    endfunction

    task automatic hs(input int which, input string name);
        int c = 0;
        @(negedge ACLK);
        while (!rdy(which) && c < 200) begin
            @(negedge ACLK);
            c++;
        end
        if (!rdy(which)) begin
            tests++; fails++;
            $display("FAIL %s_timeout: ready got 0, expected 1", name);
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic drain();
        int c = 0;
        while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && c < 500) begin
            @(posedge ACLK);
            c++;
        end
        #1;
        check("drain_empty", 64'(exp_b_q.size() + exp_r_q.size()), 0);
    endtask

    task automatic do_write(input logic [3:0] id, input int addr, input int len,
                            input int burst, input int nbeats);
        bit err;
        int a;
        err = burst_bad(len, burst) || (nbeats != len + 1);
        for (int i = 0; i < nbeats; i++) begin
            a = beat_addr(addr, len, burst, i) / BYTES;
            if (a >= DEPTH) err = 1'b1;
            else for (int b = 0; b < BYTES; b++)
                if (ws[i][b]) model_mem[a][8*b +: 8] = wd[i][8*b +: 8];
        end
        exp_b_q.push_back({id, err ? 2'b10 : 2'b00});
        AWVALID = 1'b1; AWID = id; AWADDR = 32'(addr); AWLEN = 8'(len); AWBURST = 2'(burst);
        hs(0, "aw");
        AWVALID = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
            WVALID = 1'b1; WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == nbeats - 1);
            hs(1, "w");
            WVALID = 1'b0; WLAST = 1'b0;
        end
        drain();
    endtask

    task automatic send_ar(input logic [3:0] id, input int addr, input int len, input int burst);
        ARVALID = 1'b1; ARID = id; ARADDR = 32'(addr); ARLEN = 8'(len); ARBURST = 2'(burst);
        hs(2, "ar");
        ARVALID = 1'b0;
    endtask

    task automatic push_read_model(input logic [3:0] id, input int addr, input int len, input int burst);
        int a;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, burst, i) / BYTES;
            if (a >= DEPTH) exp_r_q.push_back({id, 2'b10, i == len, 32'h0});
            else exp_r_q.push_back({id, burst_bad(len, burst) ? 2'b10 : 2'b00, i == len, model_mem[a]});
        end
    endtask

    task automatic do_read(input logic [3:0] id, input int addr, input int len, input int burst);
        push_read_model(id, addr, len, burst);
        send_ar(id, addr, len, burst);
        drain();
    endtask

    function automatic int pick_burst(inout int len);
        int r = $urandom_range(0, 9);
        if (r < 4 || r == 9) return 1;
        if (r < 6) begin
            case ($urandom_range(0, 3))
                0: len = 1; 1: len = 3; 2: len = 7; default: len = 15;
            endcase
            return 2;
        end
        if (r == 6) return 2;
        if (r == 7) return 0;
        return 3;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [43:0] cap;
        int len, burst, addr, nbeats;
        ARESETn = 1'b0;
        AWVALID = 0; AWID = 0; AWADDR = 0; AWLEN = 0; AWBURST = 0;
        WVALID = 0; WDATA = 0; WSTRB = 0; WLAST = 0;
        ARVALID = 0; ARID = 0; ARADDR = 0; ARLEN = 0; ARBURST = 0;
        repeat (3) @(posedge ACLK);
        #1;
        check("reset_outputs", {AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID,
                                RID, RDATA, RRESP, RLAST}, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check("ready_after_reset", {AWREADY, ARREADY}, 2'b11);
        @(posedge ACLK);
        #1;

        // Fill the whole memory so every later read has a defined model value.
        for (int k = 0; k < DEPTH / 16; k++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            do_write(4'(k), k * 64, 15, 1, 16);
        end

        // INCR write then read-back with RLAST on the final beat only.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(4'h5, 'h10, 3, 1, 4);
        for (int i = 0; i < 4; i++) exp_r_q.push_back({4'h6, 2'b00, i == 3, 32'(i + 1)});
        send_ar(4'h6, 'h10, 3, 1);
        drain();

        // WRAP from 0x18 visits 0x18, 0x1C, 0x10, 0x14.
        exp_r_q.push_back({4'h7, 2'b00, 1'b0, 32'd3});
        exp_r_q.push_back({4'h7, 2'b00, 1'b0, 32'd4});
        exp_r_q.push_back({4'h7, 2'b00, 1'b0, 32'd1});
        exp_r_q.push_back({4'h7, 2'b00, 1'b1, 32'd2});
        send_ar(4'h7, 'h18, 3, 2);
        drain();

        // Partial-strobe merge.
        wd[0] = 32'h1122_3344; ws[0] = 4'hF;
        do_write(4'h1, 'h40, 0, 1, 1);
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'h3;
        do_write(4'h2, 'h40, 0, 1, 1);
        exp_r_q.push_back({4'h3, 2'b00, 1'b1, 32'h1122_CCDD});
        send_ar(4'h3, 'h40, 0, 1);
        drain();

        // Last word in range, then one past the end.
        exp_r_q.push_back({4'h4, 2'b00, 1'b0, model_mem[DEPTH-1]});
        exp_r_q.push_back({4'h4, 2'b10, 1'b1, 32'h0});
        send_ar(4'h4, (DEPTH - 1) * BYTES, 1, 1);
        drain();

        // Error cases: out of range, early/late WLAST, reserved burst, bad WRAP length, FIXED.
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'(15 - i); end
        do_write(4'h8, (DEPTH - 2) * BYTES, 3, 1, 4);
        do_write(4'h9, 'h100, 3, 1, 2);
        do_write(4'hA, 'h120, 1, 1, 3);
        do_write(4'hB, 'h140, 1, 3, 2);
        do_write(4'hC, 'h160, 2, 2, 3);
        do_write(4'hD, 'h180, 3, 0, 4);
        do_read(4'hE, 'h100, 7, 1);
        do_read(4'hF, 'h140, 3, 3);
        do_read(4'h1, 'h180, 2, 0);

        // Read back-pressure mid-burst: payload must hold.
        r_auto = 1'b0;
        RREADY = 1'b1;
        push_read_model(4'h3, 'h80, 7, 1);
        send_ar(4'h3, 'h80, 7, 1);
        @(posedge ACLK);
        @(posedge ACLK);
        #1;
        RREADY = 1'b0;
        @(negedge ACLK);
        cap = {RVALID, RID, RRESP, RLAST, RDATA};
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check("stall_stable", {RVALID, RID, RRESP, RLAST, RDATA}, cap);
        end
        @(posedge ACLK);
        #1;
        RREADY = 1'b1;
        r_auto = 1'b1;
        drain();

        // Reset in the middle of a write burst: no response, memory keeps written beats.
        AWVALID = 1'b1; AWID = 4'h9; AWADDR = 32'h200; AWLEN = 8'd3; AWBURST = 2'd1;
        hs(0, "aw");
        AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            WVALID = 1'b1; WDATA = 32'hCAFE_0000 + 32'(i); WSTRB = 4'hF; WLAST = 1'b0;
            model_mem['h200 / BYTES + i] = 32'hCAFE_0000 + 32'(i);
            hs(1, "w");
        end
        WVALID = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        check("reset_mid_outputs", {AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID,
                                    RID, RDATA, RRESP, RLAST}, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check("mid_reset_ready", {AWREADY, ARREADY, BVALID, WREADY}, 4'b1100);
        repeat (4) begin @(posedge ACLK); #1; end
        check("no_bresp_after_abort", {BVALID, WREADY}, 2'b00);
        do_read(4'h2, 'h200, 3, 1);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            len   = $urandom_range(0, 15);
            burst = pick_burst(len);
            addr  = $urandom_range(0, (DEPTH + 8) * BYTES - 1);
            if ($urandom_range(0, 1) == 1) begin
                nbeats = len + 1;
                if ($urandom_range(0, 7) == 0) nbeats = (len == 0) ? 2 : len;
                for (int i = 0; i < nbeats; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
                do_write(4'($urandom), addr, len, burst, nbeats);
            end else begin
                do_read(4'($urandom), addr, len, burst);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        tests++; fails++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
